inst_queue_ctrl: RTL and testbench
==================================

Name: inst_queue_ctrl

Overview:
Instruction queue and issue sequencer that sits between the instruction fetcher and the decoder. It buffers fetched {inst, pc, pred_res} triples in a circular FIFO and presents the oldest entry to the decoder. An entry is popped when the decoder reports an issue. The queue is flushed on a RoB misprediction clear, and on a decoder front-end redirect (jal or predicted-taken branch). Flushing discards all wrong-path instructions.

Parameters:
DEPTH_LOG, 4, log2 of the queue depth; DEPTH = 2**DEPTH_LOG entries (16).
XLEN, 32, width of the inst and pc fields.

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous, active-low reset; queue empties immediately on assertion
rdy_in  input  1  global ready; when low, all state holds except reset
fetch_valid  input  1  fetcher presents a new instruction this cycle
fetch_inst  input  XLEN  fetched instruction word
fetch_pc  input  XLEN  pc of fetched instruction
fetch_pred  input  1  branch prediction bit (1 = taken) for the fetched instruction
queue_full  output  1  registered; 1 when count == DEPTH; fetcher must not advance
dec_valid  output  1  1 when count != 0 (drives the decoder's fetch_ready)
dec_inst  output  XLEN  inst of the head entry
dec_pc  output  XLEN  pc of the head entry
dec_pred  output  1  pred_res of the head entry
dec_issue  input  1  decoder issue_ready; pops the head entry at the clock edge
dec_redirect  input  1  decoder pc_change_flag; the head issues and all younger entries are wrong-path
rob_clear  input  1  RoB misprediction flush; discard everything
count  output  DEPTH_LOG+1  current occupancy

Behaviour:
- Storage: DEPTH-entry array; head and tail are DEPTH_LOG-bit pointers that wrap modulo DEPTH; count is DEPTH_LOG+1 bits.
- Reset (rst_in=0, asynchronous):
  - head = tail = count = 0.
  - Consequently queue_full = 0 and dec_valid = 0.
  - Array contents are don't-care; dec_* data outputs are don't-care while dec_valid = 0.
  - Deasserting reset mid-operation restarts from empty; no stale entry becomes visible.
- All updates occur on the posedge clk_in, only when rdy_in = 1, evaluated in priority order:
  1. rob_clear = 1:
     - head = tail = count = 0.
     - Push, pop and redirect that cycle are ignored.
  2. dec_redirect = 1 and dec_issue = 1 and dec_valid = 1:
     - The head entry is consumed; all remaining entries are discarded; head = tail, count = 0.
     - A simultaneous fetch_valid push is discarded, because it is wrong-path.
  3. Otherwise:
     - push = fetch_valid & !queue_full.
     - pop = dec_issue & dec_valid.
     - On push: write mem[tail] and advance tail by 1.
     - On pop: advance head by 1.
     - count update: +1 for push only, -1 for pop only, unchanged for push and pop together.
- dec_redirect without dec_issue is ignored; the decoder only asserts it when issue_ready is high.
- dec_issue while dec_valid = 0 is ignored; count never underflows.
- Full boundary:
  - queue_full is derived from registered count, so a push is refused when count == DEPTH even if a pop occurs the same cycle.
  - The refused fetch is not lost: the fetcher holds it while queue_full is set.
- Empty boundary:
  - No bypass; a pushed entry is first visible on dec_* the cycle after the push.
  - Latency fetch -> decoder is 1 cycle minimum.
- dec_inst, dec_pc and dec_pred are combinational reads of mem[head]; they are stable whenever head and mem[head] do not change.
- Ordering: entries pop in strict push order across pointer wrap-around.
- rdy_in = 0: pointers, count and memory hold, and outputs remain stable.

Test Plan:
- Reset and fill: release rst_in, then push 16 entries (pc 0x0,0x4,...,0x3C) with dec_issue=0 -> count=16 and queue_full=1. A 17th push (pc 0x40) is refused. Then pop 16 -> dec_pc sequence is 0x0..0x3C in order, and dec_valid=0 afterwards.
- Simultaneous push/pop and wrap: keep count=3 while streaming 40 entries with push and pop every cycle -> count stays 3, pointers wrap at least twice, and dec_pc order is exact.
- Full edge: at count=16, assert fetch_valid and dec_issue together -> count=15 and the pushed entry is dropped. The next cycle, the push succeeds and count=16.
- Redirect: queue holds pc 0x100..0x10C (4 entries), and dec_issue=dec_redirect=1 with fetch_valid=1 (pc 0x110) -> next cycle count=0 and dec_valid=0. A new push of pc 0x200 then appears as the head one cycle later.
- RoB clear priority: count=5, with rob_clear=1, dec_issue=1 and fetch_valid=1 in the same cycle -> count=0 and no entry is written.
- Async reset and rdy_in: with count=7, pull rst_in low mid-cycle -> count=0 immediately, without waiting for an edge. Separately, with rdy_in=0 and push/pop asserted for 3 cycles -> count and dec_pc are unchanged.

Source files
------------

// File: rtl/inst_queue_ctrl.sv
// -----------------------------------------------------------------------------
// inst_queue_ctrl
//
// Instruction queue between the fetcher and the decoder. Fetched
// {inst, pc, pred} triples go into a circular FIFO. The oldest entry is
// presented to the decoder, and it is popped when the decoder issues it.
// A RoB misprediction clear empties the queue. A decoder redirect (jal or
// predicted-taken branch) consumes the head entry and discards every
// younger, wrong-path entry.
//
// Ports:
//   clk_in        system clock
//   rst_in        asynchronous active-low reset; the queue empties immediately
//   rdy_in        global ready; while low, all state holds
//   fetch_valid   fetcher presents an instruction this cycle
//   fetch_inst    fetched instruction word
//   fetch_pc      pc of the fetched instruction
//   fetch_pred    branch prediction of the fetched instruction (1 = taken)
//   queue_full    registered; high when count == DEPTH
//   dec_valid     high when the queue holds at least one entry
//   dec_inst      instruction of the head entry
//   dec_pc        pc of the head entry
//   dec_pred      prediction bit of the head entry
//   dec_issue     decoder takes the head entry at this clock edge
//   dec_redirect  the head issues, and all younger entries are wrong-path
//   rob_clear     discard everything
//   count         current occupancy
// -----------------------------------------------------------------------------
module inst_queue_ctrl #(
    parameter int DEPTH_LOG = 4,
    parameter int XLEN      = 32
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 fetch_valid,
    input  logic [XLEN-1:0]      fetch_inst,
    input  logic [XLEN-1:0]      fetch_pc,
    input  logic                 fetch_pred,
    output logic                 queue_full,
    output logic                 dec_valid,
    output logic [XLEN-1:0]      dec_inst,
    output logic [XLEN-1:0]      dec_pc,
    output logic                 dec_pred,
    input  logic                 dec_issue,
    input  logic                 dec_redirect,
    input  logic                 rob_clear,
    output logic [DEPTH_LOG:0]   count
);

    localparam int                 DEPTH    = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] FULL_CNT = (DEPTH_LOG + 1)'(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic            pred;
    } entry_t;

    entry_t               r_mem [DEPTH];
    logic [DEPTH_LOG-1:0] r_head;
    logic [DEPTH_LOG-1:0] r_tail;
    logic [DEPTH_LOG:0]   r_count;
    logic                 r_full;

    logic                 w_not_empty;
    logic                 w_redirect;
    logic                 w_push;
    logic                 w_pop;
    logic [DEPTH_LOG:0]   w_count_nxt;
    entry_t               w_head_entry;

    assign w_not_empty = (r_count != '0);

    // Decide this cycle's action, in priority order:
    // clear, then redirect, then normal push/pop.
    always_comb begin
        // NOTE: every signal gets a default first, so the block cannot infer a latch.
        w_redirect  = 1'b0;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_count_nxt = r_count;
        if (rob_clear) begin
            w_count_nxt = '0;
        end else if (dec_redirect && dec_issue && w_not_empty) begin
            w_redirect  = 1'b1;
            w_count_nxt = '0;
        end else begin
            // The full test uses the registered flag, so a push is refused
            // at DEPTH even when a pop happens in the same cycle.
            w_push = fetch_valid && !r_full;
            w_pop  = dec_issue && w_not_empty;
            case ({w_push, w_pop})
                2'b10:   w_count_nxt = r_count + 1'b1;
                2'b01:   w_count_nxt = r_count - 1'b1;
                default: w_count_nxt = r_count;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
        end else if (rdy_in) begin
            // NOTE: sequential state uses non-blocking assignments, so every
            // flop samples values from before the edge.
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == FULL_CNT);
            if (rob_clear) begin
                r_head <= '0;
                r_tail <= '0;
            end else if (w_redirect) begin
                // The head issues and the younger entries are dropped. The
                // simultaneous fetch is wrong-path, so tail does not move.
                r_head <= r_tail;
            end else begin
                if (w_push) r_tail <= r_tail + 1'b1;
                if (w_pop)  r_head <= r_head + 1'b1;
            end
        end
    end

    // NOTE: the storage array has no reset. It is only read through head
    // while count != 0, so stale contents are never visible.
    always_ff @(posedge clk_in) begin
        if (rdy_in && w_push) begin
            r_mem[r_tail] <= '{inst: fetch_inst, pc: fetch_pc, pred: fetch_pred};
        end
    end

    // Combinational read of the head entry. There is no bypass, so a pushed
    // entry first appears on dec_* the cycle after the push.
    assign w_head_entry = r_mem[r_head];
    assign dec_inst     = w_head_entry.inst;
    assign dec_pc       = w_head_entry.pc;
    assign dec_pred     = w_head_entry.pred;
    assign dec_valid    = w_not_empty;
    assign queue_full   = r_full;
    assign count        = r_count;

endmodule

// File: tb/tb_inst_queue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_inst_queue_ctrl
//
// Self-checking bench for inst_queue_ctrl. Every cycle is compared against a
// queue-based reference model. Expected values come from three sources: a
// table of short vectors with constant expected results, hand-written
// multi-cycle corner sequences, and a randomized stream.
// -----------------------------------------------------------------------------
module tb_inst_queue_ctrl;

    localparam int DEPTH_LOG = 4;
    localparam int XLEN      = 32;
    localparam int DEPTH     = 1 << DEPTH_LOG;

    logic                 clk_in;
    logic                 rst_in;
    logic                 rdy_in;
    logic                 fetch_valid;
    logic [XLEN-1:0]      fetch_inst;
    logic [XLEN-1:0]      fetch_pc;
    logic                 fetch_pred;
    logic                 queue_full;
    logic                 dec_valid;
    logic [XLEN-1:0]      dec_inst;
    logic [XLEN-1:0]      dec_pc;
    logic                 dec_pred;
    logic                 dec_issue;
    logic                 dec_redirect;
    logic                 rob_clear;
    logic [DEPTH_LOG:0]   count;

    inst_queue_ctrl #(.DEPTH_LOG(DEPTH_LOG), .XLEN(XLEN)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .fetch_valid  (fetch_valid),
        .fetch_inst   (fetch_inst),
        .fetch_pc     (fetch_pc),
        .fetch_pred   (fetch_pred),
        .queue_full   (queue_full),
        .dec_valid    (dec_valid),
        .dec_inst     (dec_inst),
        .dec_pc       (dec_pc),
        .dec_pred     (dec_pred),
        .dec_issue    (dec_issue),
        .dec_redirect (dec_redirect),
        .rob_clear    (rob_clear),
        .count        (count)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic            pred;
    } entry_t;

    typedef struct {
        logic            fv;
        logic [XLEN-1:0] pc;
        logic            iss;
        logic            redir;
        logic            clr;
        logic            rdy;
        int              exp_count;
        logic            exp_valid;
        logic [XLEN-1:0] exp_pc;
    } vec_t;

    entry_t model_q[$];
    int     n_vec = 0;
    int     n_err = 0;

    function automatic logic [XLEN-1:0] mk_inst(input logic [XLEN-1:0] pc);
        return {pc[15:0], ~pc[15:0]} ^ 32'h1234_5678;
    endfunction

    function automatic logic mk_pred(input logic [XLEN-1:0] pc);
        return pc[2] ^ pc[5];
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the reference model.
    task automatic check_model();
        check("model.count", 32'(count), 32'(model_q.size()));
        check("model.valid", 32'(dec_valid), 32'(model_q.size() != 0));
        check("model.full", 32'(queue_full), 32'(model_q.size() == DEPTH));
        if (model_q.size() != 0) begin
            check("model.pc", dec_pc, model_q[0].pc);
            check("model.inst", dec_inst, model_q[0].inst);
            check("model.pred", 32'(dec_pred), 32'(model_q[0].pred));
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, advance the model, and
    // compare #1 after the edge.
    task automatic apply(input logic fv, input logic [XLEN-1:0] pc, input logic iss,
                         input logic redir, input logic clr, input logic rdy);
        bit push;
        bit pop;
        fetch_valid  = fv;
        fetch_pc     = pc;
        fetch_inst   = mk_inst(pc);
        fetch_pred   = mk_pred(pc);
        dec_issue    = iss;
        dec_redirect = redir;
        rob_clear    = clr;
        rdy_in       = rdy;
        @(posedge clk_in);
        if (rdy) begin
            if (clr) begin
                model_q.delete();
            end else if (redir && iss && model_q.size() != 0) begin
                model_q.delete();
            end else begin
                push = fv && (model_q.size() < DEPTH);
                pop  = iss && (model_q.size() != 0);
                if (pop)  void'(model_q.pop_front());
                if (push) model_q.push_back('{inst: mk_inst(pc), pc: pc, pred: mk_pred(pc)});
            end
        end
        #1;
        check_model();
    endtask

    task automatic idle();
        apply(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic push_one(input logic [XLEN-1:0] pc);
        apply(1'b1, pc, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic pop_one();
        apply(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic clear_all();
        apply(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    vec_t vecs[$];

    initial begin
        rst_in       = 1'b0;
        rdy_in       = 1'b1;
        fetch_valid  = 1'b0;
        fetch_inst   = '0;
        fetch_pc     = '0;
        fetch_pred   = 1'b0;
        dec_issue    = 1'b0;
        dec_redirect = 1'b0;
        rob_clear    = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk_in);
        #1;
        check("reset.count", 32'(count), 32'd0);
        check("reset.valid", 32'(dec_valid), 32'd0);
        check("reset.full", 32'(queue_full), 32'd0);
        @(negedge clk_in);
        rst_in = 1'b1;
        model_q.delete();

        // Table vectors: fv, pc, iss, redir, clr, rdy, count, valid, head pc.
        vecs.push_back('{1, 32'h1000, 0, 0, 0, 1, 1, 1, 32'h1000});
        vecs.push_back('{1, 32'h1004, 0, 0, 0, 1, 2, 1, 32'h1000});
        vecs.push_back('{1, 32'h1008, 1, 0, 0, 1, 2, 1, 32'h1004});
        vecs.push_back('{0, 32'h0,    1, 0, 0, 1, 1, 1, 32'h1008});
        vecs.push_back('{0, 32'h0,    1, 0, 0, 1, 0, 0, 32'h0});
        vecs.push_back('{0, 32'h0,    1, 0, 0, 1, 0, 0, 32'h0});
        vecs.push_back('{1, 32'h100C, 0, 0, 0, 0, 0, 0, 32'h0});
        vecs.push_back('{1, 32'h100C, 0, 0, 0, 1, 1, 1, 32'h100C});
        vecs.push_back('{1, 32'h1010, 0, 1, 0, 1, 2, 1, 32'h100C});
        vecs.push_back('{1, 32'h1014, 1, 0, 1, 1, 0, 0, 32'h0});
        vecs.push_back('{1, 32'h1020, 0, 0, 0, 1, 1, 1, 32'h1020});
        vecs.push_back('{1, 32'h1024, 1, 1, 0, 1, 0, 0, 32'h0});
        foreach (vecs[i]) begin
            apply(vecs[i].fv, vecs[i].pc, vecs[i].iss, vecs[i].redir, vecs[i].clr, vecs[i].rdy);
            check($sformatf("vec%0d.count", i), 32'(count), 32'(vecs[i].exp_count));
            check($sformatf("vec%0d.valid", i), 32'(dec_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) check($sformatf("vec%0d.pc", i), dec_pc, vecs[i].exp_pc);
        end

        // Fill to DEPTH, refuse a 17th push, then drain in order.
        for (int i = 0; i < DEPTH; i++) push_one(32'(i * 4));
        check("fill.count", 32'(count), 32'd16);
        check("fill.full", 32'(queue_full), 32'd1);
        push_one(32'h40);
        check("fill.refused", 32'(count), 32'd16);
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("drain.pc%0d", i), dec_pc, 32'(i * 4));
            pop_one();
        end
        check("drain.valid", 32'(dec_valid), 32'd0);

        // Steady stream at count 3, wrapping the pointers several times.
        for (int i = 0; i < 3; i++) push_one(32'h300 + 32'(i * 4));
        for (int i = 0; i < 40; i++) begin
            apply(1'b1, 32'h400 + 32'(i * 4), 1'b1, 1'b0, 1'b0, 1'b1);
            check($sformatf("stream.count%0d", i), 32'(count), 32'd3);
        end
        check("stream.head", dec_pc, 32'h400 + 32'(37 * 4));
        clear_all();

        // Full edge: push and pop together at DEPTH; the push is refused.
        for (int i = 0; i < DEPTH; i++) push_one(32'h500 + 32'(i * 4));
        apply(1'b1, 32'h600, 1'b1, 1'b0, 1'b0, 1'b1);
        check("fulledge.count", 32'(count), 32'd15);
        check("fulledge.head", dec_pc, 32'h504);
        push_one(32'h600);
        check("fulledge.retry", 32'(count), 32'd16);
        clear_all();

        // Redirect: the head issues, younger entries and the same-cycle fetch go.
        for (int i = 0; i < 4; i++) push_one(32'h100 + 32'(i * 4));
        apply(1'b1, 32'h110, 1'b1, 1'b1, 1'b0, 1'b1);
        check("redir.count", 32'(count), 32'd0);
        check("redir.valid", 32'(dec_valid), 32'd0);
        push_one(32'h200);
        check("redir.newhead", dec_pc, 32'h200);
        check("redir.newcount", 32'(count), 32'd1);
        clear_all();

        // RoB clear takes priority over push and pop.
        for (int i = 0; i < 5; i++) push_one(32'h700 + 32'(i * 4));
        apply(1'b1, 32'h7000, 1'b1, 1'b0, 1'b1, 1'b1);
        check("robclr.count", 32'(count), 32'd0);
        idle();
        check("robclr.nowrite", 32'(dec_valid), 32'd0);

        // Asynchronous reset in the middle of a cycle.
        for (int i = 0; i < 7; i++) push_one(32'h800 + 32'(i * 4));
        #2;
        rst_in = 1'b0;
        #1;
        check("areset.count", 32'(count), 32'd0);
        check("areset.valid", 32'(dec_valid), 32'd0);
        model_q.delete();
        @(negedge clk_in);
        rst_in = 1'b1;
        idle();

        // rdy_in low: push/pop requests are held off.
        for (int i = 0; i < 3; i++) push_one(32'h900 + 32'(i * 4));
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 32'hA00, 1'b1, 1'b0, 1'b0, 1'b0);
            check($sformatf("rdy.count%0d", i), 32'(count), 32'd3);
            check($sformatf("rdy.pc%0d", i), dec_pc, 32'h900);
        end

        // Randomized stream. Each 100-cycle phase changes the push/pop bias
        // so that both the full and the empty boundaries are reached.
        for (int i = 0; i < 800; i++) begin
            int          ph;
            logic        fv;
            logic        iss;
            logic        redir;
            logic        clr;
            logic        rdy;
            ph    = (i / 100) % 3;
            fv    = (ph == 0) ? ($urandom_range(0, 9) != 0) :
                    (ph == 1) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 1) != 0);
            iss   = (ph == 0) ? ($urandom_range(0, 9) < 3) :
                    (ph == 1) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 1) != 0);
            redir = ($urandom_range(0, 24) == 0);
            clr   = ($urandom_range(0, 99) == 0);
            rdy   = ($urandom_range(0, 7) != 0);
            apply(fv, $urandom(), iss, redir, clr, rdy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
